dvi_capture: RTL

DVI_CAPTURE -- requirements
Module: dvi_capture

---
 rtl/dvi_pkg.sv | 18 +
 rtl/dvi_edge_det.sv | 23 ++
 rtl/dvi_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dvi_pkg.sv
// Shared types and constants for the DVI capture front end.
package dvi_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int COORD_W      = 11;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } dvi_state_e;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/dvi_edge_det.sv
// Registers a level and flags its rising/falling transitions, all three aligned.
module dvi_edge_det (
    input  logic fbclk,
    input  logic fbclk_rst_b,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise  <= d & ~level;
            fall  <= ~d & level;
            level <= d;
        end
    end

endmodule

// File: rtl/dvi_capture.sv
// DDR DVI pixel capture with frame-timing lock detection.
// Optional line/frame/error statistics under `define DVI_CAPTURE_STATS_EN.
module dvi_capture
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               fbclk,
    input  logic               fbclk_rst_b,
    input  logic [11:0]        dvi_d_rise,
    input  logic [11:0]        dvi_d_fall,
    input  logic               dvi_de,
    input  logic               dvi_hs,
    input  logic               dvi_vs,
    output logic               pix_valid,
    output logic [23:0]        pix_rgb,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               locked,
    output logic [10:0]        meas_width,
    output logic [10:0]        meas_height,
    output logic [15:0]        err_count
);

    localparam logic [COORD_W-1:0] H_LEN    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LEN    = COORD_W'(V_ACTIVE);
    localparam logic               SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    logic               hs_act, vs_act;
    logic [11:0]        rise_q, fall_q;
    logic               hs_q;
    logic               de_l, de_rise, de_fall;
    logic               vs_l, vs_rise, vs_fall;
    logic               unused_sig;
    logic [COORD_W-1:0] x_cnt, y_cnt, y_line;
    logic               width_bad, overrun, height_bad, lose_lock, pix_ok;
    logic               frame_good, stream_on;
    dvi_state_e         state;

    assign hs_act = dvi_hs ^ SYNC_INV;
    assign vs_act = dvi_vs ^ SYNC_INV;

    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            rise_q <= '0;
            fall_q <= '0;
            hs_q   <= 1'b0;
        end else begin
            rise_q <= dvi_d_rise;
            fall_q <= dvi_d_fall;
            hs_q   <= hs_act;
        end
    end

    dvi_edge_det u_de_edge (
        .fbclk       (fbclk),
        .fbclk_rst_b (fbclk_rst_b),
        .d           (dvi_de),
        .level       (de_l),
        .rise        (de_rise),
        .fall        (de_fall)
    );

    dvi_edge_det u_vs_edge (
        .fbclk       (fbclk),
        .fbclk_rst_b (fbclk_rst_b),
        .d           (vs_act),
        .level       (vs_l),
        .rise        (vs_rise),
        .fall        (vs_fall)
    );

    assign unused_sig = ^{hs_q, de_rise, vs_l, vs_fall};

    // A line ending in the same cycle as the frame edge is counted first.
    assign y_line     = de_fall ? sat_inc(y_cnt) : y_cnt;
    assign width_bad  = de_fall && (x_cnt != H_LEN);
    assign overrun    = de_l && (x_cnt >= H_LEN);
    assign height_bad = vs_rise && (y_line != V_LEN);
    assign lose_lock  = (state == LOCKED) && (overrun || width_bad || height_bad);
    assign pix_ok     = de_l && (state == LOCKED) && stream_on && !overrun;

    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (de_l)
                x_cnt <= sat_inc(x_cnt);
            else if (de_fall)
                x_cnt <= '0;
            y_cnt <= vs_rise ? '0 : y_line;
        end
    end

    // stream_on holds off output until a frame boundary has been seen in LOCKED.
    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            state      <= SEARCH;
            frame_good <= 1'b0;
            stream_on  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state      <= ARMED;
                        frame_good <= 1'b1;
                    end
                end
                ARMED: begin
                    if (vs_rise) begin
                        if (frame_good && !width_bad && (y_line == V_LEN)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            frame_good <= 1'b1;
                        end
                    end else if (width_bad) begin
                        frame_good <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (lose_lock) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        stream_on <= 1'b0;
                    end else if (vs_rise) begin
                        stream_on <= 1'b1;
                    end
                end
                default: begin
                    state     <= SEARCH;
                    locked    <= 1'b0;
                    stream_on <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_rgb   <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            pix_valid <= pix_ok;
            pix_sof   <= pix_ok && (x_cnt == '0) && (y_cnt == '0);
            pix_eol   <= pix_ok && (x_cnt == H_LAST);
            if (pix_ok) begin
                pix_rgb <= {fall_q[11:4], fall_q[3:0], rise_q[11:8], rise_q[7:0]};
                pix_x   <= x_cnt;
                pix_y   <= y_cnt;
            end
        end
    end

`ifdef DVI_CAPTURE_STATS_EN
    always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
        if (!fbclk_rst_b) begin
            meas_width  <= '0;
            meas_height <= '0;
            err_count   <= '0;
        end else begin
            if (de_fall)
                meas_width <= x_cnt;
            if (vs_rise)
                meas_height <= y_line;
            if (lose_lock && (err_count != '1))
                err_count <= err_count + 16'd1;
        end
    end
`else
    assign meas_width  = '0;
    assign meas_height = '0;
    assign err_count   = '0;
`endif

endmodule
